// File: rtl/filter_capture_if.sv
// Bundle of the filter_capture data, control and readout signals.
// The slave side is the capture block; the master side is its driver.
interface filter_capture_if #(
  parameter int N_CH   = 21,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64
);
  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int AW = $clog2(DEPTH);

  logic [N_CH*DATA_W-1:0] ch_data;
  logic [SW-1:0]          ch_sel;
  logic [DATA_W-1:0]      threshold;
  logic                   arm;
  logic                   busy;
  logic                   done;
  logic                   rd_en;
  logic [DATA_W-1:0]      rd_data;
  logic                   rd_valid;
  logic                   rd_last;
  logic [DATA_W-1:0]      peak_value;
  logic [AW-1:0]          peak_index;
  logic                   forced;

  modport slave (
    input  ch_data, ch_sel, threshold, arm, rd_en,
    output busy, done, rd_data, rd_valid, rd_last, peak_value, peak_index, forced
  );

  modport master (
    output ch_data, ch_sel, threshold, arm, rd_en,
    input  busy, done, rd_data, rd_valid, rd_last, peak_value, peak_index, forced
  );
endinterface

// File: rtl/filter_capture.sv
// Triggered capture of one filter channel into a DEPTH-sample ring buffer,
// with pre-trigger history, peak measurement and a handshake readout.
// Optional feature: define FILTER_CAPTURE_TIMEOUT_EN to force a trigger
// after TIMEOUT cycles in WAIT_TRIG (reported on forced).
module filter_capture #(
  parameter int N_CH     = 21,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 64,
  parameter int PRE_TRIG = 8,
  parameter int TIMEOUT  = 65535
) (
  input  logic         clk,
  input  logic         reset,
  filter_capture_if.slave bus
);
  localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, PREFILL, WAIT_TRIG, POST, READY, READ} state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [DATA_W-1:0] thr_q, thr_d;
  logic [DATA_W-1:0] s0_q, s0_d, s1_q, s1_d;
  logic [CW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     rd_cnt_q, rd_cnt_d;
  logic [DATA_W-1:0] peak_q, peak_d;
  logic [AW-1:0]     pidx_q, pidx_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic              we, rd_fire, crossing, fire;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;
`ifdef FILTER_CAPTURE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic              forced_q, forced_d;
`endif

  assign crossing = ($signed(s0_q) > $signed(thr_q)) && ($signed(s1_q) <= $signed(thr_q));

  // Next-state, capture control, peak tracking and readout pointer.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    thr_d      = thr_q;
    wr_cnt_d   = wr_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_cnt_d   = rd_cnt_q;
    peak_d     = peak_q;
    pidx_d     = pidx_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    we         = 1'b0;
    rd_fire    = 1'b0;
    fire       = crossing;
`ifdef FILTER_CAPTURE_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
    forced_d   = forced_q;
    fire       = crossing || (to_cnt_q == TW'(TIMEOUT - 1));
`endif
    case (state_q)
      IDLE: if (bus.arm) begin
        sel_d    = (int'(bus.ch_sel) < N_CH) ? bus.ch_sel : '0;
        thr_d    = bus.threshold;
        wr_cnt_d = '0;
        peak_d   = '0;
        pidx_d   = '0;
`ifdef FILTER_CAPTURE_TIMEOUT_EN
        forced_d = 1'b0;
`endif
        state_d  = PREFILL;
      end
      PREFILL: begin
        we       = 1'b1;
        wr_cnt_d = wr_cnt_q + 1'b1;
        if (wr_cnt_q == CW'(PRE_TRIG - 1)) begin
          state_d = WAIT_TRIG;
`ifdef FILTER_CAPTURE_TIMEOUT_EN
          to_cnt_d = '0;
`endif
        end
      end
      WAIT_TRIG: begin
        we = 1'b1;
`ifdef FILTER_CAPTURE_TIMEOUT_EN
        to_cnt_d = to_cnt_q + 1'b1;
`endif
        if (fire) begin
          // Oldest window sample sits PRE_TRIG slots behind the trigger write.
          rd_ptr_d = wr_ptr_q - AW'(PRE_TRIG);
          peak_d   = s0_q;
          pidx_d   = AW'(PRE_TRIG);
          wr_cnt_d = '0;
`ifdef FILTER_CAPTURE_TIMEOUT_EN
          forced_d = !crossing;
`endif
          state_d  = POST;
        end
      end
      POST: begin
        we       = 1'b1;
        wr_cnt_d = wr_cnt_q + 1'b1;
        // Strict compare so a tie keeps the earliest position.
        if ($signed(s0_q) > $signed(peak_q)) begin
          peak_d = s0_q;
          pidx_d = AW'(PRE_TRIG + 1) + AW'(wr_cnt_q);
        end
        if (wr_cnt_q == CW'(DEPTH - PRE_TRIG - 2)) begin
          rd_cnt_d = '0;
          state_d  = READY;
        end
      end
      READY, READ: if (bus.rd_en) begin
        rd_fire    = 1'b1;
        rd_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + 1'b1;
        rd_cnt_d   = rd_cnt_q + 1'b1;
        state_d    = READ;
        if (rd_cnt_q == AW'(DEPTH - 1)) begin
          rd_last_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (we) wr_ptr_d = wr_ptr_q + 1'b1;
    // The channel latched by this cycle's arm is already used for s0.
    s0_d   = bus.ch_data[sel_d*DATA_W +: DATA_W];
    s1_d   = s0_q;
    busy_d = (state_q != IDLE);
    done_d = (state_q == READY) || (state_q == READ);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      thr_q      <= '0;
      s0_q       <= '0;
      s1_q       <= '0;
      wr_cnt_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_cnt_q   <= '0;
      peak_q     <= '0;
      pidx_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
`ifdef FILTER_CAPTURE_TIMEOUT_EN
      to_cnt_q   <= '0;
      forced_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      thr_q      <= thr_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_cnt_q   <= rd_cnt_d;
      peak_q     <= peak_d;
      pidx_q     <= pidx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
`ifdef FILTER_CAPTURE_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
      forced_q   <= forced_d;
`endif
    end
  end

  // Ring buffer: one write port, one registered read port, no reset.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr_q] <= s0_q;
    if (rd_fire) ram_q <= mem[rd_ptr_q];
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_last    = rd_last_q;
  assign bus.rd_data    = rd_valid_q ? ram_q : '0;
  assign bus.peak_value = peak_q;
  assign bus.peak_index = pidx_q;
`ifdef FILTER_CAPTURE_TIMEOUT_EN
  assign bus.forced     = forced_q;
`else
  // No timeout logic: forced folds to constant 0 (TIMEOUT is never negative).
  assign bus.forced     = (TIMEOUT < 0);
`endif
endmodule
